ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Multi-cycle integer multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register operands and funct field held in ID/EX and executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It owns the architectural HI/LO registers and raises a stall request to the hazard logic while an operation is in flight. Iterative radix-2 datapath: one result bit per cycle.

## Interface
- XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- md_req  in  1  ID/EX holds a valid R-type instruction whose funct is one of the eight mul/div/HI/LO codes; 0 for bubbles.
- funct  in  6  funct field from ID/EX: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- rs_val  in  XLEN  forwarded RS operand (dividend / multiplicand / MTHI-MTLO source).
- rt_val  in  XLEN  forwarded RT operand (divisor / multiplier).
- hi_out  out  XLEN  current HI register.
- lo_out  out  XLEN  current LO register.
- md_rdata  out  XLEN  combinational: hi_out when funct=MFHI, else lo_out.
- md_busy  out  1  high in RUN and FIX states.
- md_stall  out  1  combinational: md_req & md_busy.

## Operation
- States: IDLE, RUN, FIX. Iteration counter cnt, 5 bits for XLEN=32.
- IDLE, md_req=1, funct=MULT/MULTU/DIV/DIVU: latch op, sign flags, operand magnitudes (unsigned ops: raw values; signed ops: two's-complement absolute values); cnt<=0; go to RUN.
- IDLE, md_req=1, funct=MTHI/MTLO: HI/LO <= rs_val on that edge; stay IDLE.
- IDLE, MFHI/MFLO: no state change; md_rdata is valid in the same cycle.
- RUN, multiply: shift-add, 64-bit unsigned product accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN: cnt increments each edge. After the edge with cnt=XLEN-1, go to FIX.
- FIX (1 cycle) performs sign correction, then writes HI/LO and goes to IDLE.
  - MULT: product negated if sign(rs)^sign(rt).
  - DIV: quotient negated if sign(rs)^sign(rt); remainder takes the sign of rs.
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: HI=remainder, LO=quotient.
- Divide by zero (rt_val=0, DIV or DIVU): full latency retained. Result HI=rs_val (original, unsigned view), LO=0xFFFFFFFF. No sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Any md_req while busy (including MFHI/MFLO/MTHI/MTLO) produces md_stall=1. Upstream holds the instruction in ID/EX and re-presents it. It is accepted in the first cycle with md_busy=0.
- branch_taken/flush does not cancel an in-flight operation (it is older than the flushed instructions). Flushed instructions arrive as md_req=0.
- HI/LO change only on MTHI/MTLO accept or FIX. Otherwise hi_out/lo_out hold.

## Timing
- Reset (rst=0, any time including mid-RUN): state=IDLE, cnt=0, HI=0, LO=0, accumulators=0, md_busy=0. md_stall=0 and md_rdata=0 follow combinationally. Operation aborted, no partial write.
- Op accepted at edge E0: md_busy=1 from E0 until E0+33. RUN spans edges E0+1..E0+32, FIX at edge E0+33.
- HI/LO are visible and md_busy=0 after E0+33, i.e. 33-cycle issue-to-result latency.
- A mul/div presented in the cycle right after E0+33 is accepted back-to-back, with no dead cycle.
- MTHI/MTLO: 1-cycle latency (visible after the accept edge). MFHI/MFLO: 0-cycle combinational read.
- md_stall has no registered delay. The hazard logic uses it in the same cycle.

## Test plan
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> md_busy high 33 cycles; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD(-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV rs=0xFFFFFFF9(-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100 rt=0 -> after 33 cycles HI=0x00000064, LO=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT accepted, MFLO held on md_req the next cycle:
  - md_stall=1 for the remaining 32 busy cycles.
  - The cycle md_busy drops, md_stall=0 and md_rdata equals the new LO.
- MTHI rs=0x12345678 while idle -> hi_out=0x12345678 after one edge. MTLO while busy -> stalled, LO unchanged until accepted after FIX.
- DIVU started, rst driven low at RUN cycle 10 -> immediately md_busy=0, HI=LO=0. After release, a new MULTU 3*5 yields LO=15, HI=0 after 33 cycles.

Source files
------------

// File: rtl/md_if.sv
// md_if: ID/EX-side handshake and HI/LO read bus for the multiply/divide unit.
interface md_if #(parameter int XLEN = 32);
    logic            md_req;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;
    logic [XLEN-1:0] md_rdata;
    logic            md_busy;
    logic            md_stall;
    modport master (output md_req, funct, rs_val, rt_val,
                    input  hi_out, lo_out, md_rdata, md_busy, md_stall);
    modport slave  (input  md_req, funct, rs_val, rt_val,
                    output hi_out, lo_out, md_rdata, md_busy, md_stall);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Multiply and divide share one 2*XLEN accumulator: {partial, multiplier} or {remainder, quotient}.
module ex_muldiv_unit #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    md_if.slave md
);
    localparam int CW = $clog2(XLEN);
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
    logic              div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic              is_mul, is_div, sgn;
    logic [XLEN-1:0]   abs_rs, abs_rt, quo, rem;
    logic [XLEN:0]     add, rem_sh, diff;
    logic [2*XLEN-1:0] mstep, dstep, prod;
    always_comb begin
        is_mul = md.funct == F_MULT || md.funct == F_MULTU;
        is_div = md.funct == F_DIV || md.funct == F_DIVU;
        sgn    = md.funct == F_MULT || md.funct == F_DIV;
        abs_rs = sgn && md.rs_val[XLEN-1] ? -md.rs_val : md.rs_val;
        abs_rt = sgn && md.rt_val[XLEN-1] ? -md.rt_val : md.rt_val;
        add    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mstep  = {acc_q[0] ? add : {1'b0, acc_q[2*XLEN-1:XLEN]}, acc_q[XLEN-1:1]};
        rem_sh = acc_q[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, b_q};
        // Restoring step: keep the shifted remainder when the trial subtract borrows.
        dstep  = {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc_q[XLEN-2:0], ~diff[XLEN]};
        prod   = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem    = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        rs_d    = rs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        if (state_q == IDLE) begin
            if (md.md_req && (is_mul || is_div)) begin
                state_d = RUN;
                cnt_d   = '0;
                div_d   = is_div;
                neg_d   = sgn && (md.rs_val[XLEN-1] ^ md.rt_val[XLEN-1]);
                rneg_d  = sgn && is_div && md.rs_val[XLEN-1];
                dz_d    = is_div && md.rt_val == '0;
                rs_d    = md.rs_val;
                b_d     = is_mul ? abs_rs : abs_rt;
                acc_d   = {{XLEN{1'b0}}, is_mul ? abs_rt : abs_rs};
            end else if (md.md_req && md.funct == F_MTHI) begin
                hi_d = md.rs_val;
            end else if (md.md_req && md.funct == F_MTLO) begin
                lo_d = md.rs_val;
            end
        end else if (state_q == RUN) begin
            acc_d = div_q ? dstep : mstep;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN - 1))
                state_d = FIX;
        end else begin
            state_d = IDLE;
            hi_d    = div_q ? (dz_q ? rs_q : rem) : prod[2*XLEN-1:XLEN];
            lo_d    = div_q ? (dz_q ? '1 : quo) : prod[XLEN-1:0];
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            rs_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            rs_q    <= rs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end
    assign md.hi_out   = hi_q;
    assign md.lo_out   = lo_q;
    assign md.md_rdata = md.funct == F_MFHI ? hi_q : lo_q;
    assign md.md_busy  = state_q != IDLE;
    assign md.md_stall = md.md_req && md.md_busy;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: random mul/div/HI/LO traffic checked every cycle against an arithmetic model,
// plus hand-computed results for the corner cases.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    md_if #(.XLEN(32)) md();
    ex_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .md(md));
    int passed = 0;
    int total  = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (f == 6'h19) p = {32'b0, a} * {32'b0, b};
        else if (f == 6'h18) p = 64'(sa * sb);
        else if (b == 0) p = {a, 32'hFFFFFFFF};
        else if (f == 6'h1B) p = {a % b, a / b};
        else begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction
    // Model: HI/LO, cycles of busy remaining, and the result that lands when the count expires.
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_hi   <= 0;
            m_lo   <= 0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end else if (md.md_req) begin
            if (md.funct >= 6'h18 && md.funct <= 6'h1B) begin
                m_res  <= ref_res(md.funct, md.rs_val, md.rt_val);
                m_left <= 33;
            end else if (md.funct == 6'h11) m_hi <= md.rs_val;
            else if (md.funct == 6'h13) m_lo <= md.rs_val;
        end
    end
    always @(negedge clk) begin
        if (rst) begin
            chk("busy", 32'(md.md_busy), 32'(m_left > 0));
            chk("stall", 32'(md.md_stall), 32'(md.md_req && m_left > 0));
            chk("hi", md.hi_out, m_hi);
            chk("lo", md.lo_out, m_lo);
            chk("rdata", md.md_rdata, md.funct == 6'h10 ? m_hi : m_lo);
        end
    end
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        md.md_req = 1'b1;
        md.funct  = f;
        md.rs_val = a;
        md.rt_val = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md.md_busy) begin
                @(posedge clk);
                #1 md.md_req = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 1, 0);
        md.md_req = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md.md_busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask
    task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        issue(f, a, b);
        wait_idle();
    endtask
    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(1, 9));
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        logic [5:0] fl [8] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        int n;
        rst = 1'b0;
        md.md_req = 1'b0;
        md.funct  = 6'h0;
        md.rs_val = 0;
        md.rt_val = 0;
        #12;
        chk("reset_hi", md.hi_out, 0);
        chk("reset_lo", md.lo_out, 0);
        chk("reset_busy", 32'(md.md_busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md.md_busy) break;
            n++;
        end
        chk("multu_busy_cycles", n, 33);
        chk("multu_hi", md.hi_out, 32'hFFFFFFFE);
        chk("multu_lo", md.lo_out, 32'h00000001);
        run(6'h18, 32'hFFFFFFFD, 32'd7);
        chk("mult_hi", md.hi_out, 32'hFFFFFFFF);
        chk("mult_lo", md.lo_out, 32'hFFFFFFEB);
        run(6'h1A, 32'hFFFFFFF9, 32'd2);
        chk("div_hi", md.hi_out, 32'hFFFFFFFF);
        chk("div_lo", md.lo_out, 32'hFFFFFFFD);
        run(6'h1B, 32'd100, 32'd0);
        chk("divu0_hi", md.hi_out, 32'h00000064);
        chk("divu0_lo", md.lo_out, 32'hFFFFFFFF);
        run(6'h1A, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_hi", md.hi_out, 32'h0);
        chk("divovf_lo", md.lo_out, 32'h80000000);
        issue(6'h18, 32'd12345, 32'hFFFFFFFE);
        @(posedge clk);
        #1 md.md_req = 1'b1;
        md.funct = 6'h12;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!md.md_busy) break;
            n += 32'(md.md_stall);
        end
        chk("mflo_stall_cycles", n, 32);
        chk("mflo_stall_drop", 32'(md.md_stall), 0);
        chk("mflo_rdata", md.md_rdata, 32'hFFFF9F8E);
        @(posedge clk);
        #1 md.md_req = 1'b0;
        issue(6'h11, 32'h12345678, 32'h0);
        chk("mthi_hi", md.hi_out, 32'h12345678);
        issue(6'h19, 32'd3, 32'd5);
        issue(6'h13, 32'hCAFEF00D, 32'h0);
        chk("mtlo_busy_lo", md.lo_out, 32'hCAFEF00D);
        chk("mtlo_busy_hi", md.hi_out, 32'h0);
        issue(6'h1B, 32'd1000, 32'd7);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(md.md_busy), 0);
        chk("rst_hi", md.hi_out, 0);
        chk("rst_lo", md.lo_out, 0);
        chk("rst_rdata", md.md_rdata, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        run(6'h19, 32'd3, 32'd5);
        chk("post_rst_hi", md.hi_out, 32'h0);
        chk("post_rst_lo", md.lo_out, 32'd15);
        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 issue(fl[$urandom % 8], pick(), pick());
        end
        wait_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
